// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 serial receiver: FSM encoding and frame constants.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz GCLK / 115200 baud

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer signal bundle: serial pin in, byte holding register out.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                 rxIN;
  logic                 rxAckIN;
  logic [DATA_BITS-1:0] rxDataOUT;
  logic                 rxValidOUT;
  logic                 rxFrameErrOUT;
  logic                 rxOverrunOUT;
  logic                 rxIdleOUT;

  // master: the receiver itself; slave: the pin driver / byte consumer
  modport master (
    input  rxIN, rxAckIN,
    output rxDataOUT, rxValidOUT, rxFrameErrOUT, rxOverrunOUT, rxIdleOUT
  );

  modport slave (
    output rxIN, rxAckIN,
    input  rxDataOUT, rxValidOUT, rxFrameErrOUT, rxOverrunOUT, rxIdleOUT
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; reset value selectable per pin.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {2{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[0], async_in};
    end
  end

  assign sync_out = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling from a fixed divider, one-entry holding
// register with valid/ack handshake, framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clockIN,
  input  logic nRxResetIN,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Counters are loaded with N-1 so the sample happens in the cycle the count reaches zero.
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic rs;
  logic rs_prev_reg;

  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 brk_reg, brk_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 ferr_reg, ferr_next;
  logic                 ovr_reg, ovr_next;
  logic                 deliver;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk      (clockIN),
    .rst_n    (nRxResetIN),
    .async_in (bus.rxIN),
    .sync_out (rs)
  );

  always_ff @(posedge clockIN or negedge nRxResetIN) begin
    if (!nRxResetIN) begin
      rs_prev_reg <= 1'b1;
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      brk_reg     <= 1'b0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      rs_prev_reg <= rs;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      brk_reg     <= brk_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
      ovr_reg     <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    brk_next   = brk_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    ferr_next  = 1'b0;
    ovr_next   = ovr_reg;
    deliver    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!rs && rs_prev_reg) begin
          state_next = ST_START;
          cnt_next   = HALF_LOAD;
          bit_next   = '0;
        end
      end
      ST_START: begin
        if (cnt_reg == '0) begin
          if (rs) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DATA;
            cnt_next   = BIT_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_reg == '0) begin
          shift_next = {rs, shift_reg[DATA_BITS-1:1]};
          cnt_next   = BIT_LOAD;
          if (bit_reg == LAST_BIT) begin
            state_next = ST_STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_STOP: begin
        // After a low stop bit, wait out the break without re-reporting it.
        if (brk_reg) begin
          if (rs) begin
            state_next = ST_IDLE;
            brk_next   = 1'b0;
          end
        end else if (cnt_reg == '0) begin
          if (rs) begin
            deliver    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            ferr_next = 1'b1;
            brk_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (deliver) begin
      if (!valid_reg || bus.rxAckIN) begin
        data_next  = shift_reg;
        valid_next = 1'b1;
        if (bus.rxAckIN && valid_reg) begin
          ovr_next = 1'b0;
        end
      end else begin
        ovr_next = 1'b1;
      end
    end else if (bus.rxAckIN && valid_reg) begin
      valid_next = 1'b0;
      ovr_next   = 1'b0;
    end
  end

  assign bus.rxDataOUT     = data_reg;
  assign bus.rxValidOUT    = valid_reg;
  assign bus.rxFrameErrOUT = ferr_reg;
  assign bus.rxOverrunOUT  = ovr_reg;
  assign bus.rxIdleOUT     = (state_reg == ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed vector table, hand-built corner
// sequences and a randomized run against a transaction-level holding-register model.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int  CPB    = 16;
  localparam real BIT_NS = 160.0;  // CPB * 10 ns clock

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clockIN    (clk),
    .nRxResetIN (rst_n),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;
  int err_pulses = 0;
  int lat;
  int low_cnt;
  int e0;

  always @(negedge clk) if (bus.rxFrameErrOUT) err_pulses++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, int'(bus.rxValidOUT), 0);
    check({tag, "_data"}, int'(bus.rxDataOUT), 0);
    check({tag, "_ferr"}, int'(bus.rxFrameErrOUT), 0);
    check({tag, "_ovr"}, int'(bus.rxOverrunOUT), 0);
    check({tag, "_idle"}, int'(bus.rxIdleOUT), 1);
  endtask

  // Drives one 8N1 frame (LSB first). A low stop bit is held for three bit times.
  task automatic send_frame(input logic [7:0] b, input real bit_ns, input bit stop_low);
    bus.rxIN = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      bus.rxIN = b[i];
      #(bit_ns);
    end
    if (stop_low) begin
      bus.rxIN = 1'b0;
      #(3.0 * bit_ns);
    end
    bus.rxIN = 1'b1;
    #(bit_ns);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.rxAckIN = 1'b1;
    @(negedge clk);
    bus.rxAckIN = 1'b0;
  endtask

  typedef struct {
    bit         do_ack;
    bit         do_send;
    logic [7:0] b;
    bit         stop_low;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_ovr;
    int         exp_err;
  } vec_t;

  vec_t vecs[10];

  // Transaction-level model of the holding register.
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_ovr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rxIN    = 1'b1;
    bus.rxAckIN = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Exact-rate 0xA5 with delivery latency counted in rising edges from the pin edge
    fork
      send_frame(8'hA5, BIT_NS, 1'b0);
      begin
        lat = 0;
        while (!bus.rxValidOUT && lat < 400) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    check("a5_latency", lat, 2 + 8 + 9 * CPB + 1);
    check("a5_data", int'(bus.rxDataOUT), 8'hA5);
    check("a5_ovr", int'(bus.rxOverrunOUT), 0);
    check("a5_err", err_pulses, 0);
    $display("txn a5 latency=%0d data=%02h", lat, bus.rxDataOUT);
    #(2.0 * BIT_NS);
    ack_pulse();
    @(negedge clk);
    check("lone_ack_valid", int'(bus.rxValidOUT), 0);

    vecs[0] = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 1'b0, 1};
    vecs[1] = '{1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 0};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 0};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 0};
    vecs[7] = '{1'b0, 1'b1, 8'h7E, 1'b1, 1'b1, 8'hC3, 1'b0, 1};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b1, 0};
    vecs[9] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 0};

    for (int i = 0; i < 10; i++) begin
      e0 = err_pulses;
      if (vecs[i].do_ack) ack_pulse();
      if (vecs[i].do_send) begin
        send_frame(vecs[i].b, BIT_NS, vecs[i].stop_low);
        #(2.0 * BIT_NS);
      end
      @(negedge clk);
      $display("txn vec%0d ack=%0d send=%0d byte=%02h stop_low=%0d -> valid=%0d data=%02h ovr=%0d",
               i, vecs[i].do_ack, vecs[i].do_send, vecs[i].b, vecs[i].stop_low,
               bus.rxValidOUT, bus.rxDataOUT, bus.rxOverrunOUT);
      check($sformatf("vec%0d_valid", i), int'(bus.rxValidOUT), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i), int'(bus.rxDataOUT), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_ovr", i), int'(bus.rxOverrunOUT), int'(vecs[i].exp_ovr));
      check($sformatf("vec%0d_err", i), err_pulses - e0, vecs[i].exp_err);
    end

    // Four-cycle glitch on the idle line: START entered, then rejected silently
    e0 = err_pulses;
    @(negedge clk);
    bus.rxIN = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_in_start", int'(bus.rxIdleOUT), 0);
    bus.rxIN = 1'b1;
    repeat (30) @(negedge clk);
    $display("txn glitch idle=%0d valid=%0d", bus.rxIdleOUT, bus.rxValidOUT);
    check("glitch_idle", int'(bus.rxIdleOUT), 1);
    check("glitch_err", err_pulses - e0, 0);
    check("glitch_data", int'(bus.rxDataOUT), 8'hFF);

    // Force an overrun, then ack exactly in the delivery cycle of 0x55
    send_frame(8'h44, BIT_NS, 1'b0);
    #(2.0 * BIT_NS);
    @(negedge clk);
    check("ovr44_ovr", int'(bus.rxOverrunOUT), 1);
    check("ovr44_data", int'(bus.rxDataOUT), 8'hFF);
    fork
      send_frame(8'h55, BIT_NS, 1'b0);
      begin
        repeat (2 + 8 + 9 * CPB) @(posedge clk);
        @(negedge clk);
        bus.rxAckIN = 1'b1;
        @(posedge clk);
        #1;
        bus.rxAckIN = 1'b0;
        check("simul_data", int'(bus.rxDataOUT), 8'h55);
        check("simul_valid", int'(bus.rxValidOUT), 1);
        check("simul_ovr", int'(bus.rxOverrunOUT), 0);
      end
      begin
        low_cnt = 0;
        repeat (170) begin
          @(negedge clk);
          if (!bus.rxValidOUT) low_cnt++;
        end
      end
    join
    check("simul_no_valid_gap", low_cnt, 0);
    $display("txn simul_ack data=%02h valid=%0d ovr=%0d", bus.rxDataOUT, bus.rxValidOUT, bus.rxOverrunOUT);
    #(2.0 * BIT_NS);

    // Reset in the middle of data bit 4 of 0xFF, then 0x0F
    e0 = err_pulses;
    fork
      send_frame(8'hFF, BIT_NS, 1'b0);
      begin
        #(5.5 * BIT_NS);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("midreset");
        rst_n = 1'b1;
      end
    join
    #(2.0 * BIT_NS);
    @(negedge clk);
    check("post_reset_valid", int'(bus.rxValidOUT), 0);
    send_frame(8'h0F, BIT_NS, 1'b0);
    #(2.0 * BIT_NS);
    @(negedge clk);
    $display("txn after_reset data=%02h valid=%0d", bus.rxDataOUT, bus.rxValidOUT);
    check("rst0f_data", int'(bus.rxDataOUT), 8'h0F);
    check("rst0f_valid", int'(bus.rxValidOUT), 1);
    check("rst0f_err", err_pulses - e0, 0);

    // +/-3% baud skew
    ack_pulse();
    send_frame(8'h5A, BIT_NS * 1.03, 1'b0);
    #(2.0 * BIT_NS);
    @(negedge clk);
    check("skew_slow_data", int'(bus.rxDataOUT), 8'h5A);
    check("skew_slow_valid", int'(bus.rxValidOUT), 1);
    ack_pulse();
    send_frame(8'hA6, BIT_NS * 0.97, 1'b0);
    #(2.0 * BIT_NS);
    @(negedge clk);
    check("skew_fast_data", int'(bus.rxDataOUT), 8'hA6);
    check("skew_fast_ovr", int'(bus.rxOverrunOUT), 0);
    $display("txn skew data=%02h", bus.rxDataOUT);

    // Randomized frames, acks and framing errors against the model
    m_valid = 1'b1;
    m_data  = 8'hA6;
    m_ovr   = 1'b0;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit         sl;
      bit         ak;
      real        sk;
      int         gap;
      b   = 8'($urandom);
      sl  = ($urandom_range(0, 7) == 0);
      ak  = ($urandom_range(0, 2) == 0);
      sk  = 1.0 + (real'(int'($urandom_range(0, 40))) - 20.0) / 1000.0;
      gap = int'($urandom_range(1, 3));
      e0  = err_pulses;
      if (ak) begin
        ack_pulse();
        if (m_valid) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
      end
      send_frame(b, BIT_NS * sk, sl);
      #(real'(gap) * BIT_NS);
      if (!sl) begin
        if (!m_valid) begin
          m_valid = 1'b1;
          m_data  = b;
        end else begin
          m_ovr = 1'b1;
        end
      end
      @(negedge clk);
      $display("txn rnd%0d ack=%0d byte=%02h stop_low=%0d skew=%0.3f -> valid=%0d data=%02h ovr=%0d",
               n, ak, b, sl, sk, bus.rxValidOUT, bus.rxDataOUT, bus.rxOverrunOUT);
      check($sformatf("rnd%0d_valid", n), int'(bus.rxValidOUT), int'(m_valid));
      check($sformatf("rnd%0d_data", n), int'(bus.rxDataOUT), int'(m_data));
      check($sformatf("rnd%0d_ovr", n), int'(bus.rxOverrunOUT), int'(m_ovr));
      check($sformatf("rnd%0d_err", n), err_pulses - e0, sl ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
